// File: rtl/cc_cond_unit_if.sv
// E-stage to M-stage bundle for the condition-code unit.
// The master drives the E-stage side; the slave is the unit itself.
interface cc_cond_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [1:0]       control;
  logic             set_cc;
  logic             cc_block;
  logic [3:0]       ifun;
  logic             stall;
  logic             bubble;
  logic             e_cnd;
  logic [2:0]       cc;
  logic             m_valid;
  logic [WIDTH-1:0] m_valE;
  logic             m_cnd;

  modport master (
    output in_valid, alu_a, alu_b, alu_out,
    output control, set_cc, cc_block, ifun,
    output stall, bubble,
    input  e_cnd, cc, m_valid, m_valE, m_cnd
  );

  modport slave (
    input  in_valid, alu_a, alu_b, alu_out,
    input  control, set_cc, cc_block, ifun,
    input  stall, bubble,
    output e_cnd, cc, m_valid, m_valE, m_cnd
  );
endinterface

// File: rtl/cc_cond_unit.sv
// Y86-64 condition codes, jXX/cmovXX condition and
// the E->M pipeline register for valE/cnd.
module cc_cond_unit #(
  parameter int WIDTH = 64
) (
  input logic          clk,
  input logic          rst,
  cc_cond_unit_if.slave bus
);
  localparam int S = WIDTH - 1;

  logic             w_zf;
  logic             w_sf;
  logic             w_of;
  logic             w_cc_we;
  logic             w_lt;
  logic             w_cnd;
  logic [2:0]       r_cc;
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_valE;
  logic             r_m_cnd;

  assign w_zf = (bus.alu_out == '0);
  assign w_sf = bus.alu_out[S];

  always_comb begin
    w_of = 1'b0;
    case (bus.control)
      2'd0: w_of = (bus.alu_a[S] == bus.alu_b[S]) &&
                   (bus.alu_out[S] != bus.alu_a[S]);
      2'd1: w_of = (bus.alu_a[S] != bus.alu_b[S]) &&
                   (bus.alu_out[S] != bus.alu_b[S]);
      default: w_of = 1'b0;
    endcase
  end

  assign w_cc_we = bus.in_valid & bus.set_cc & ~bus.cc_block &
                   ~bus.stall & ~bus.bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc <= 3'b100;
    end else if (w_cc_we) begin
      r_cc <= {w_zf, w_sf, w_of};
    end
  end

  // Condition reads the committed CC, not this cycle's flags
  assign w_lt = r_cc[1] ^ r_cc[0];

  always_comb begin
    w_cnd = 1'b0;
    case (bus.ifun)
      4'd0:    w_cnd = 1'b1;
      4'd1:    w_cnd = w_lt | r_cc[2];
      4'd2:    w_cnd = w_lt;
      4'd3:    w_cnd = r_cc[2];
      4'd4:    w_cnd = ~r_cc[2];
      4'd5:    w_cnd = ~w_lt;
      4'd6:    w_cnd = ~w_lt & ~r_cc[2];
      default: w_cnd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_valE  <= '0;
      r_m_cnd   <= 1'b0;
    end else if (bus.bubble) begin
      r_m_valid <= 1'b0;
      r_m_valE  <= '0;
      r_m_cnd   <= 1'b0;
    end else if (!bus.stall) begin
      r_m_valid <= bus.in_valid;
      r_m_valE  <= bus.alu_out;
      r_m_cnd   <= w_cnd & bus.in_valid;
    end
  end

  assign bus.e_cnd   = w_cnd;
  assign bus.cc      = r_cc;
  assign bus.m_valid = r_m_valid;
  assign bus.m_valE  = r_m_valE;
  assign bus.m_cnd   = r_m_cnd;
endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit with a per-cycle
// reference model and hand-computed literal checks.
module tb_cc_cond_unit;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  logic chk_en;
  int   n_cmp;
  int   n_bad;

  cc_cond_unit_if #(.WIDTH(64)) bus ();

  cc_cond_unit #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic        mzf, msf, mof;
  logic        mv, mcnd;
  logic [63:0] mvale;

  function automatic logic [63:0] alu(input logic [1:0] c,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
    case (c)
      2'd0:    return b + a;
      2'd1:    return b - a;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Overflow = true signed result not representable in 64 bits
  function automatic logic ovf(input logic [1:0] c,
                               input logic [63:0] a,
                               input logic [63:0] b);
    logic signed [65:0] sa, sb, r, lim;
    sa  = $signed(a);
    sb  = $signed(b);
    lim = 66'sd1 <<< 63;
    if (c == 2'd0)      r = sb + sa;
    else if (c == 2'd1) r = sb - sa;
    else                return 1'b0;
    return (r >= lim) || (r < -lim);
  endfunction

  function automatic logic cond(input logic [3:0] f);
    logic lt;
    lt = (msf != mof);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return lt || mzf;
      4'd2:    return lt;
      4'd3:    return mzf;
      4'd4:    return !mzf;
      4'd5:    return !lt;
      4'd6:    return !lt && !mzf;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mzf <= 1'b1; msf <= 1'b0; mof <= 1'b0;
      mv <= 1'b0; mvale <= '0; mcnd <= 1'b0;
    end else begin
      if (bus.in_valid && bus.set_cc && !bus.cc_block &&
          !bus.stall && !bus.bubble) begin
        mzf <= (bus.alu_out == 64'd0);
        msf <= ($signed(bus.alu_out) < 0);
        mof <= ovf(bus.control, bus.alu_a, bus.alu_b);
      end
      if (bus.bubble) begin
        mv <= 1'b0; mvale <= '0; mcnd <= 1'b0;
      end else if (!bus.stall) begin
        mv    <= bus.in_valid;
        mvale <= bus.alu_out;
        mcnd  <= cond(bus.ifun) && bus.in_valid;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cc", {61'd0, bus.cc}, {61'd0, mzf, msf, mof});
      chk("m_valid", {63'd0, bus.m_valid}, {63'd0, mv});
      chk("m_valE", bus.m_valE, mvale);
      chk("m_cnd", {63'd0, bus.m_cnd}, {63'd0, mcnd});
      chk("m_e_cnd", {63'd0, bus.e_cnd}, {63'd0, cond(bus.ifun)});
    end
  end

  task automatic drv(input logic v, input logic [1:0] c,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic sc, input logic cb,
                     input logic [3:0] f, input logic st,
                     input logic bu);
    bus.in_valid = v;
    bus.control  = c;
    bus.alu_a    = a;
    bus.alu_b    = b;
    bus.alu_out  = alu(c, a, b);
    bus.set_cc   = sc;
    bus.cc_block = cb;
    bus.ifun     = f;
    bus.stall    = st;
    bus.bubble   = bu;
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    chk(nm, act, exp);
  endtask

  logic [1:0]  st_c [5];
  logic [63:0] st_a [5];
  logic [63:0] st_b [5];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk_en = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    lit("rst_cc", {61'd0, bus.cc}, 64'd4);
    lit("rst_mv", {63'd0, bus.m_valid}, 64'd0);
    lit("rst_valE", bus.m_valE, 64'd0);
    lit("rst_mcnd", {63'd0, bus.m_cnd}, 64'd0);

    drv(1, 0, MAXP, 64'd1, 1, 0, 0, 0, 0);
    tick;
    lit("add_ovf_cc", {61'd0, bus.cc}, 64'd3);
    lit("add_ovf_valE", bus.m_valE, MINN);

    drv(1, 2, 64'hFFFF_FFFF_FFFF_FFF0, 64'hF, 1, 0, 3, 0, 0);
    #1;
    lit("and_old_e", {63'd0, bus.e_cnd}, 64'd0);
    tick;
    lit("and_cc", {61'd0, bus.cc}, 64'd4);
    drv(0, 0, 0, 0, 0, 0, 3, 0, 0);
    #1;
    lit("e_eq", {63'd0, bus.e_cnd}, 64'd1);
    bus.ifun = 4'd4;
    #1;
    lit("e_ne", {63'd0, bus.e_cnd}, 64'd0);
    tick;

    drv(1, 1, 64'd5, 64'd3, 1, 0, 2, 0, 0);
    #1;
    lit("sub_old_l", {63'd0, bus.e_cnd}, 64'd0);
    tick;
    lit("sub_cc", {61'd0, bus.cc}, 64'd2);
    drv(1, 0, 0, 0, 0, 0, 2, 0, 0);
    #1;
    lit("sub_new_l", {63'd0, bus.e_cnd}, 64'd1);
    tick;
    lit("jxx_mcnd", {63'd0, bus.m_cnd}, 64'd1);

    drv(1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1, 1, 0, 0, 0);
    tick;
    lit("blk_cc", {61'd0, bus.cc}, 64'd2);
    lit("blk_valE", bus.m_valE, ONES);

    drv(1, 3, 64'h1234, 64'd0, 0, 0, 0, 0, 0);
    tick;
    lit("ld_valE", bus.m_valE, 64'h1234);
    drv(1, 0, 64'd1, 64'd1, 1, 0, 0, 1, 0);
    tick;
    tick;
    lit("stall_valE", bus.m_valE, 64'h1234);
    lit("stall_cc", {61'd0, bus.cc}, 64'd2);
    drv(1, 0, 64'd1, 64'd1, 1, 0, 0, 1, 1);
    tick;
    lit("bub_mv", {63'd0, bus.m_valid}, 64'd0);
    lit("bub_valE", bus.m_valE, 64'd0);
    lit("bub_cc", {61'd0, bus.cc}, 64'd2);

    drv(1, 1, MINN, 64'd0, 1, 0, 0, 0, 0);
    tick;
    lit("sub_min_cc", {61'd0, bus.cc}, 64'd3);

    drv(1, 0, 64'd1, 64'd1, 1, 0, 0, 1, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    lit("midrst_cc", {61'd0, bus.cc}, 64'd4);
    lit("midrst_mv", {63'd0, bus.m_valid}, 64'd0);

    st_c[0] = 2'd0; st_a[0] = 64'd1; st_b[0] = 64'd1;
    st_c[1] = 2'd0; st_a[1] = MINN;  st_b[1] = MINN;
    st_c[2] = 2'd1; st_a[2] = 64'd5; st_b[2] = 64'd3;
    st_c[3] = 2'd0; st_a[3] = MAXP;  st_b[3] = 64'd1;
    st_c[4] = 2'd2; st_a[4] = 64'd0; st_b[4] = 64'd0;
    for (int s = 0; s < 5; s++) begin
      drv(1, st_c[s], st_a[s], st_b[s], 1, 0, 0, 0, 0);
      tick;
      for (int f = 0; f < 16; f++) begin
        drv(1, 2'd2, 64'd0, 64'd0, 0, 0, 4'(f), 0, 0);
        tick;
      end
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cc_cond_unit.md
# cc_cond_unit

Condition-code and branch-condition consumer for the 64-bit ALU in the Y86-64 pipeline. It sits at the execute/memory boundary and receives the ALU operands, result and `control` code. From these it derives ZF/SF/OF and holds them in the CC register. It evaluates the jXX/cmovXX condition against the committed CC and registers the result and condition into the M-stage, with stall and bubble support.

## Interface
Parameters:
- `WIDTH`, 64, datapath width; all flag rules below use bit `WIDTH-1` as the sign bit.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: E-stage holds a real instruction this cycle.
- `alu_a` in WIDTH: ALU operand A (signed).
- `alu_b` in WIDTH: ALU operand B (signed).
- `alu_out` in WIDTH: ALU result (signed).
- `control` in 2: ALU op code. 0 = add (b+a), 1 = sub (b−a), 2 = and, 3 = xor.
- `set_cc` in 1: the instruction is OPq and must update CC.
- `cc_block` in 1: exception downstream; suppress the CC write.
- `ifun` in 4: condition code. 0 = always, 1 = le, 2 = l, 3 = e, 4 = ne, 5 = ge, 6 = g; 7–15 = never.
- `stall` in 1: hold the M-stage register.
- `bubble` in 1: load a NOP into the M-stage register.
- `e_cnd` out 1: combinational condition result, evaluated from the current CC register.
- `cc` out 3: {ZF, SF, OF} register.
- `m_valid` out 1: registered M-stage valid.
- `m_valE` out WIDTH: registered ALU result.
- `m_cnd` out 1: registered condition result.

## Operation
- Flag derivation, combinational from the inputs:
  - ZF = (`alu_out` == 0).
  - SF = `alu_out[WIDTH-1]`.
  - OF for add: a and b have the same sign and out's sign differs.
  - OF for sub: a and b have different signs and out's sign differs from b's.
  - OF for and/xor: 0.
- CC write:
  - Enabled by `in_valid & set_cc & ~cc_block & ~stall & ~bubble`.
  - Otherwise CC holds.
- Condition evaluation uses the CC register value at the start of the cycle, never the flags being computed this cycle:
  - le = (SF^OF)|ZF
  - l = SF^OF
  - e = ZF
  - ne = ~ZF
  - ge = ~(SF^OF)
  - g = ~(SF^OF)&~ZF
- M register priority: `rst` > `bubble` > `stall` > normal load.
  - Normal load: `m_valid` ← `in_valid`, `m_valE` ← `alu_out`, `m_cnd` ← `e_cnd & in_valid`.
  - Bubble: `m_valid` = 0, `m_valE` = 0, `m_cnd` = 0.
  - Stall: all M outputs hold.
- No handling of ALU exceptions. `alu_out` is taken as given; the unit does not recompute the ALU result.

## Timing
- Reset values, after one `rst` edge:
  - `cc` = 3'b100 (ZF=1, SF=0, OF=0).
  - `m_valid` = 0, `m_valE` = 0, `m_cnd` = 0.
- `rst` asserted mid-stream overrides `stall`, `bubble` and `set_cc` in the same cycle.
- Latency:
  - CC is visible on `cc` one cycle after the OPq's E cycle.
  - `m_valE`/`m_cnd` appear one cycle after the E cycle.
  - `e_cnd` is zero-latency from `ifun` and `cc`.
- Back-to-back instructions:
  - An OPq in cycle N followed by a jXX in cycle N+1: the jXX sees the OPq's flags.
  - A jXX in the same cycle as a CC write sees the old flags.
- `stall` and `bubble` both high: bubble wins, and the CC write is suppressed.
- `cc_block` high only suppresses the CC write; the M register still loads normally.
- Sign and wrap:
  - add 0x7FFF…F + 1 → 0x8000…0 sets OF=1, SF=1.
  - sub 0 − 0x8000…0 (b=0, a=min) → OF=1.

## Test plan
- Reset, then idle → `cc`=100, `m_valid`=0, `m_valE`=0, `m_cnd`=0.
- add a=0x7FFF_FFFF_FFFF_FFFF, b=1, out=0x8000_0000_0000_0000, `set_cc`=1 → next cycle `cc`=011, `m_valE`=0x8000_0000_0000_0000.
- and a=0xFFFF_FFFF_FFFF_FFF0, b=0x0000_0000_0000_000F, out=0, `set_cc`=1 → `cc`=100. Then `ifun`=3 (e) → `e_cnd`=1; `ifun`=4 (ne) → `e_cnd`=0.
- sub a=5, b=3, out=−2 with `set_cc`, then `ifun`=2 (l) in the same cycle → `e_cnd` uses the old CC (reset 100 → l=0). Next cycle → l=1.
- `cc_block`=1 with `set_cc`=1, out=0xFFFF_FFFF_FFFF_FFFF → `cc` unchanged, `m_valE`=0xFFFF_FFFF_FFFF_FFFF.
- Load `m_valE`=0x1234, then `stall`=1 for 2 cycles with a new `alu_out` → `m_valE` stays 0x1234. Then `stall`=`bubble`=1 → `m_valid`=0, `m_valE`=0, `cc` unchanged.
